// File: rtl/l2cache_arbiter.sv
// Round-robin arbiter that shares one L2 request port among NUM_REQ L1 caches.
// One transaction in flight. The winning request is latched and held on the L2 port until l2_resp_i.
module l2cache_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  localparam int IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_read_i,
  input  logic [NUM_REQ-1:0]                   req_write_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                   req_resp_o,
  output logic [DATA_WIDTH-1:0]                req_rdata_o,
  output logic                                 l2_read_o,
  output logic                                 l2_write_o,
  output logic [ADDR_WIDTH-1:0]                l2_addr_o,
  output logic [DATA_WIDTH-1:0]                l2_wdata_o,
  input  logic                                 l2_resp_i,
  input  logic [DATA_WIDTH-1:0]                l2_rdata_i,
  output logic                                 busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           rr_ptr_q, rr_ptr_d, grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic                    l2_read_q, l2_read_d, l2_write_q, l2_write_d;
  logic [NUM_REQ-1:0]      resp_q, resp_d;
  logic [NUM_REQ-1:0]      req_any;
  logic                    win_found;
  logic [IW-1:0]           win_idx;
  logic [IW:0]             scan;

  assign req_any = req_read_i | req_write_i;

  // Scan from the far end back toward rr_ptr so the nearest requester is the last to be assigned and wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      scan = {1'b0, rr_ptr_q} + (IW+1)'(off);
      if (scan >= (IW+1)'(NUM_REQ)) scan = scan - (IW+1)'(NUM_REQ);
      if (req_any[scan[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    l2_read_d  = l2_read_q;
    l2_write_d = l2_write_q;
    resp_d     = '0;
    case (state_q)
      IDLE: if (win_found) begin
        grant_d    = win_idx;
        addr_d     = req_addr_i[win_idx];
        wdata_d    = req_wdata_i[win_idx];
        // A requester raising read and write together is served as a write.
        l2_write_d = req_write_i[win_idx];
        l2_read_d  = req_read_i[win_idx] & ~req_write_i[win_idx];
        state_d    = ISSUE;
      end
      ISSUE: if (l2_resp_i) begin
        rdata_d          = l2_rdata_i;
        l2_read_d        = 1'b0;
        l2_write_d       = 1'b0;
        resp_d[grant_q]  = 1'b1;
        rr_ptr_d         = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d          = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      l2_read_q  <= 1'b0;
      l2_write_q <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      l2_read_q  <= l2_read_d;
      l2_write_q <= l2_write_d;
      resp_q     <= resp_d;
    end
  end

  assign req_resp_o  = resp_q;
  assign req_rdata_o = rdata_q;
  assign l2_read_o   = l2_read_q;
  assign l2_write_o  = l2_write_q;
  assign l2_addr_o   = addr_q;
  assign l2_wdata_o  = wdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_l2cache_arbiter.sv
// Directed and randomized bench for l2cache_arbiter.
// Expected grants come from a transaction-level round-robin model.
module tb_l2cache_arbiter;
  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         req_read = '0, req_write = '0, req_resp;
  logic [N-1:0][AW-1:0] req_addr = '0;
  logic [N-1:0][DW-1:0] req_wdata = '0;
  logic [DW-1:0]        req_rdata, l2_wdata, l2_rdata = '0;
  logic                 l2_read, l2_write, l2_resp = 1'b0, busy;
  logic [AW-1:0]        l2_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int ptr   = 0;
  logic [DW-1:0] last_rd = '0;

  l2cache_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read_i(req_read), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .req_resp_o(req_resp), .req_rdata_o(req_rdata),
    .l2_read_o(l2_read), .l2_write_o(l2_write),
    .l2_addr_o(l2_addr), .l2_wdata_o(l2_wdata),
    .l2_resp_i(l2_resp), .l2_rdata_i(l2_rdata),
    .busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Round-robin rule: first requester at or after ptr, wrapping modulo N.
  function automatic int pick(input int p, input logic [N-1:0] m);
    for (int off = 0; off < N; off++)
      if (m[(p + off) % N]) return (p + off) % N;
    return -1;
  endfunction

  // Serve one transaction whose requests are already driven and whose cycle 0 is the current cycle.
  // l2_read_o/l2_write_o are held for wait_cyc+1 cycles before l2_resp_i is sampled.
  task automatic serve(input int wait_cyc, input logic [DW-1:0] rd);
    int w;
    logic er, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    w = pick(ptr, req_read | req_write);
    if (w < 0) return;
    ew = req_write[w];
    er = req_read[w] & ~req_write[w];
    ea = req_addr[w];
    ed = req_wdata[w];
    tick();
    chk("busy_issue", DW'(busy), DW'(1'b1));
    chk("l2_read", DW'(l2_read), DW'(er));
    chk("l2_write", DW'(l2_write), DW'(ew));
    chk("l2_addr", DW'(l2_addr), DW'(ea));
    if (ew) chk("l2_wdata", l2_wdata, ed);
    repeat (wait_cyc) begin
      req_addr[w]  = $urandom;
      req_wdata[w] = rnd_line();
      tick();
      chk("l2_addr_hold", DW'(l2_addr), DW'(ea));
      chk("l2_rw_hold", DW'({l2_read, l2_write}), DW'({er, ew}));
      chk("no_early_resp", DW'(req_resp), DW'(2'b00));
    end
    l2_resp  = 1'b1;
    l2_rdata = rd;
    tick();
    l2_resp  = 1'b0;
    l2_rdata = rnd_line();
    chk("req_resp", DW'(req_resp), DW'(2'b01 << w));
    chk("l2_drop", DW'({l2_read, l2_write}), DW'(2'b00));
    chk("busy_done", DW'(busy), DW'(1'b1));
    if (er) begin
      chk("req_rdata", req_rdata, rd);
      last_rd = rd;
    end
    req_read[w]  = 1'b0;
    req_write[w] = 1'b0;
    ptr = (w + 1) % N;
    tick();
    chk("resp_pulse_end", DW'(req_resp), DW'(2'b00));
    chk("busy_idle", DW'(busy), DW'(1'b0));
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_l2_rw", DW'({l2_read, l2_write}), DW'(2'b00));
    chk("rst_resp", DW'(req_resp), DW'(2'b00));
    chk("rst_busy", DW'(busy), DW'(1'b0));
    chk("rst_addr", DW'(l2_addr), DW'(32'h0));
    chk("rst_rdata", req_rdata, '0);
    rst_n = 1'b1;

    // Single read from requester 0; l2_resp sampled in cycle 5, req_resp in cycle 6
    req_read[0] = 1'b1;
    req_addr[0] = 32'h1000_0040;
    serve(4, {32{8'hAB}});

    // Stray l2_resp in IDLE produces no resp and leaves req_rdata alone
    l2_resp  = 1'b1;
    l2_rdata = rnd_line();
    tick();
    l2_resp = 1'b0;
    chk("stray_busy", DW'(busy), DW'(1'b0));
    tick();
    chk("stray_resp", DW'(req_resp), DW'(2'b00));
    chk("stray_rdata", req_rdata, last_rd);

    // Reset in the middle of ISSUE aborts the read from requester 1 (rr_ptr is 1 here)
    req_read[1] = 1'b1;
    req_addr[1] = 32'h2000_0080;
    tick();
    chk("pre_abort_l2_read", DW'(l2_read), DW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_l2_rw", DW'({l2_read, l2_write}), DW'(2'b00));
    chk("abort_busy", DW'(busy), DW'(1'b0));
    chk("abort_resp", DW'(req_resp), DW'(2'b00));
    req_read = '0;
    #2 rst_n = 1'b1;
    ptr = 0;
    tick();
    chk("post_abort_idle", DW'(busy), DW'(1'b0));

    // Contention: both held, then both again after rr_ptr wraps
    req_read = 2'b11;
    req_addr[0] = 32'h0000_1000;
    req_addr[1] = 32'h0000_2000;
    serve(1, rnd_line());
    serve(2, rnd_line());
    req_read = 2'b11;
    serve(0, rnd_line());
    serve(0, rnd_line());

    // Fairness: requester 1 held, requester 0 re-requests right after each resp
    for (int t = 0; t < 8; t++) begin
      req_read[1] = 1'b1;
      req_read[0] = 1'b1;
      req_addr[0] = $urandom;
      serve(t % 3, rnd_line());
    end
    req_read = '0;
    tick();

    // Write from requester 1
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h3000_00C0;
    req_wdata[1] = {32{8'h5A}};
    serve(2, rnd_line());

    // Randomized traffic, including read+write on one requester treated as a write
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_read[i] | req_write[i]) && ($urandom_range(0, 3) != 0)) begin
          {req_read[i], req_write[i]} = 2'($urandom_range(1, 3));
          req_addr[i]  = $urandom;
          req_wdata[i] = rnd_line();
        end
      end
      if ((req_read | req_write) == '0) begin
        req_read[t % N] = 1'b1;
        req_addr[t % N] = $urandom;
      end
      serve($urandom_range(0, 3), rnd_line());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
